// File: rtl/elevator_pkg.sv
// Shared types for the elevator call scheduler and the stepper-motor driver.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        MOVING,
        DOOR_OPEN
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int FLOOR_W_DEFAULT = 2;
    typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Move-command handshake between the call scheduler (master) and the motor driver (slave).
interface elevator_call_scheduler_if #(
    parameter int FLOOR_W = 2
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [FLOOR_W-1:0] cmd_target;
    logic               cmd_dir;
    logic [FLOOR_W-1:0] cmd_dist;
    logic               motor_done;

    modport master (
        output cmd_valid, cmd_target, cmd_dir, cmd_dist,
        input  cmd_ready, motor_done
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_dir, cmd_dist,
        output cmd_ready, motor_done
    );
endinterface

// File: rtl/elevator_target_sel.sv
// Combinational SCAN selector: nearest pending floor ahead in dir, else nearest behind with dir reversed.
module elevator_target_sel
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                dir,
    output logic                found,
    output logic [FLOOR_W-1:0]  target,
    output logic                new_dir
);

    logic               up_found;
    logic               dn_found;
    logic [FLOOR_W-1:0] up_idx;
    logic [FLOOR_W-1:0] dn_idx;

    // Descending scan leaves the lowest floor above; ascending scan leaves the highest floor below.
    always_comb begin
        up_found = 1'b0;
        dn_found = 1'b0;
        up_idx   = '0;
        dn_idx   = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                up_found = 1'b1;
                up_idx   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                dn_found = 1'b1;
                dn_idx   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found   = up_found | dn_found;
        target  = '0;
        new_dir = dir;
        if (dir == DIR_UP) begin
            if (up_found) begin
                target  = up_idx;
                new_dir = DIR_UP;
            end else if (dn_found) begin
                target  = dn_idx;
                new_dir = DIR_DOWN;
            end
        end else begin
            if (dn_found) begin
                target  = dn_idx;
                new_dir = DIR_DOWN;
            end else if (up_found) begin
                target  = up_idx;
                new_dir = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls, issues SCAN-ordered moves, holds a door dwell.
// Optional macro ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open while high.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS       = 4,
    parameter int FLOOR_W        = 2,
    parameter int DOOR_DWELL_CYC = 100_000_000
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [N_FLOORS-1:0] call_pe,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    elevator_call_scheduler_if.master cmd,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving,
    output logic                door_open
);

    localparam int DWELL_W = $clog2(DOOR_DWELL_CYC + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_DWELL_CYC - 1);

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                dir_q, dir_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                valid_q, valid_d;
    logic [FLOOR_W-1:0]  target_q, target_d;
    logic                cmddir_q, cmddir_d;
    logic [FLOOR_W-1:0]  dist_q, dist_d;
    logic                moving_q, moving_d;
    logic                door_q, door_d;

    logic                sel_found;
    logic [FLOOR_W-1:0]  sel_target;
    logic                sel_dir;
    logic [FLOOR_W-1:0]  sel_dist;
    logic [N_FLOORS-1:0] cur_mask;
    logic [N_FLOORS-1:0] tgt_mask;
    logic                cur_call;
    logic                hold;
    logic                dwell_reload;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    elevator_target_sel #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_target_sel (
        .pending       (pending_q),
        .current_floor (floor_q),
        .dir           (dir_q),
        .found         (sel_found),
        .target        (sel_target),
        .new_dir       (sel_dir)
    );

    // One-hot masks avoid indexing past N_FLOORS when the floor width has spare codes.
    assign cur_mask     = N_FLOORS'(1) << floor_q;
    assign tgt_mask     = N_FLOORS'(1) << target_q;
    assign cur_call     = |(call_pe & cur_mask);
    assign dwell_reload = (state_q == DOOR_OPEN) && (cur_call || hold);
    assign sel_dist     = (sel_dir == DIR_UP) ? (sel_target - floor_q) : (floor_q - sel_target);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_UP;
            pending_q <= '0;
            dwell_q   <= '0;
            valid_q   <= 1'b0;
            target_q  <= '0;
            cmddir_q  <= 1'b0;
            dist_q    <= '0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
            valid_q   <= valid_d;
            target_q  <= target_d;
            cmddir_q  <= cmddir_d;
            dist_q    <= dist_d;
            moving_q  <= moving_d;
            door_q    <= door_d;
        end
    end

    // A call for the floor the car is parked at opens the door instead of issuing a move.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cur_call) begin
                    state_d = DOOR_OPEN;
                end else if (sel_found) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd.cmd_ready) begin
                    state_d = MOVING;
                end
            end
            MOVING: begin
                if (cmd.motor_done) begin
                    state_d = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (!dwell_reload && (dwell_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        floor_d   = floor_q;
        dir_d     = dir_q;
        pending_d = pending_q | call_pe;
        dwell_d   = dwell_q;
        target_d  = target_q;
        cmddir_d  = cmddir_q;
        dist_d    = dist_q;
        case (state_q)
            IDLE: begin
                pending_d = pending_q | (call_pe & ~cur_mask);
                if (cur_call) begin
                    dwell_d = DWELL_LOAD;
                end else if (sel_found) begin
                    target_d = sel_target;
                    cmddir_d = sel_dir;
                    dir_d    = sel_dir;
                    dist_d   = sel_dist;
                end
            end
            MOVING: begin
                if (cmd.motor_done) begin
                    floor_d   = target_q;
                    pending_d = (pending_q | call_pe) & ~tgt_mask;
                    dwell_d   = DWELL_LOAD;
                end
            end
            DOOR_OPEN: begin
                pending_d = pending_q | (call_pe & ~cur_mask);
                if (dwell_reload) begin
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: ;
        endcase
        valid_d  = (state_d == ISSUE);
        moving_d = (state_d == MOVING);
        door_d   = (state_d == DOOR_OPEN);
    end

    assign cmd.cmd_valid  = valid_q;
    assign cmd.cmd_target = target_q;
    assign cmd.cmd_dir    = cmddir_q;
    assign cmd.cmd_dist   = dist_q;
    assign current_floor  = floor_q;
    assign pending        = pending_q;
    assign moving         = moving_q;
    assign door_open      = door_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed self-checking bench for elevator_call_scheduler (4 floors, 8-cycle dwell).
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [3:0] call_pe;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif
    floor_t     current_floor;
    logic [3:0] pending;
    logic       moving;
    logic       door_open;

    int vectors     = 0;
    int miscompares = 0;

    elevator_call_scheduler_if #(.FLOOR_W(2)) cmd_if ();

    elevator_call_scheduler #(
        .N_FLOORS       (4),
        .FLOOR_W        (2),
        .DOOR_DWELL_CYC (8)
    ) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .call_pe       (call_pe),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold     (door_hold),
`endif
        .cmd           (cmd_if),
        .current_floor (current_floor),
        .pending       (pending),
        .moving        (moving),
        .door_open     (door_open)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!cmd_if.cmd_valid && k < 40) begin
            tick();
            k++;
        end
        vectors++;
        if (cmd_if.cmd_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: cmd_valid=%b required 1", name, cmd_if.cmd_valid);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((door_open || moving || cmd_if.cmd_valid) && k < 40) begin
            tick();
            k++;
        end
        vectors++;
        if (door_open !== 1'b0 || moving !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s idle timeout: door_open=%b moving=%b required 0/0", name, door_open, moving);
        end
    endtask

    task automatic pulse_done();
        cmd_if.motor_done = 1'b1;
        tick();
        cmd_if.motor_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        call_pe = '0;
        cmd_if.cmd_ready  = 1'b1;
        cmd_if.motor_done = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        #12;
        reset_p = 1'b0;
        tick();
        vectors++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_cmd: got %b required 000000",
                     {cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist});
        end
        vectors++;
        if ({current_floor, pending, moving, door_open} !== 8'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %b required 00000000",
                     {current_floor, pending, moving, door_open});
        end
    endtask

    task automatic test_basic_move();
        int cnt = 0;
        call_pe = 4'b0100;
        tick();
        call_pe = '0;
        vectors++;
        if (pending !== 4'b0100 || cmd_if.cmd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_latch: pending=%b valid=%b required 0100/0", pending, cmd_if.cmd_valid);
        end
        tick();
        vectors++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== {1'b1, 2'd2, 1'b0, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL basic_cmd: valid/target/dir/dist=%b/%0d/%b/%0d required 1/2/0/2",
                     cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist);
        end
        tick();
        vectors++;
        if (moving !== 1'b1 || cmd_if.cmd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_moving: moving=%b valid=%b required 1/0", moving, cmd_if.cmd_valid);
        end
        pulse_done();
        vectors++;
        if (current_floor !== 2'd2 || pending !== 4'b0000 || door_open !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_arrive: floor=%0d pending=%b door=%b required 2/0000/1",
                     current_floor, pending, door_open);
        end
        for (int i = 0; i < 20; i++) begin
            if (door_open) cnt++;
            tick();
        end
        vectors++;
        if (cnt !== 8) begin
            miscompares++;
            $display("[TB] FAIL basic_dwell: door_open cycles=%0d required 8", cnt);
        end
    endtask

    task automatic test_scan_order();
        call_pe = 4'b1001;
        tick();
        call_pe = '0;
        tick();
        vectors++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== {1'b1, 2'd3, 1'b0, 2'd1}) begin
            miscompares++;
            $display("[TB] FAIL scan_first: valid/target/dir/dist=%b/%0d/%b/%0d required 1/3/0/1",
                     cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist);
        end
        tick();
        pulse_done();
        vectors++;
        if (current_floor !== 2'd3 || pending !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL scan_arrive3: floor=%0d pending=%b required 3/0001", current_floor, pending);
        end
        wait_valid("scan_second");
        vectors++;
        if ({cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== {2'd0, 1'b1, 2'd3}) begin
            miscompares++;
            $display("[TB] FAIL scan_reverse: target/dir/dist=%0d/%b/%0d required 0/1/3",
                     cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist);
        end
        tick();
        pulse_done();
        wait_idle("scan");
    endtask

    task automatic test_backpressure();
        cmd_if.cmd_ready = 1'b0;
        call_pe = 4'b0010;
        tick();
        call_pe = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist, moving} !== {1'b1, 2'd1, 1'b0, 2'd1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: valid/target/dir/dist/moving=%b/%0d/%b/%0d/%b required 1/1/0/1/0",
                         i, cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist, moving);
            end
            tick();
        end
        cmd_if.cmd_ready = 1'b1;
        tick();
        vectors++;
        if (moving !== 1'b1 || cmd_if.cmd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_accept: moving=%b valid=%b required 1/0", moving, cmd_if.cmd_valid);
        end
        pulse_done();
        vectors++;
        if (current_floor !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL bp_arrive: floor=%0d required 1", current_floor);
        end
        wait_idle("bp");
    endtask

    task automatic test_current_floor_call();
        int  cnt = 0;
        logic saw_valid = 1'b0;
        call_pe = 4'b0010;
        tick();
        call_pe = '0;
        vectors++;
        if (door_open !== 1'b1 || pending !== 4'b0000 || cmd_if.cmd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL here_open: door=%b pending=%b valid=%b required 1/0000/0",
                     door_open, pending, cmd_if.cmd_valid);
        end
        tick();
        tick();
        tick();
        call_pe = 4'b0010;
        tick();
        call_pe = '0;
        for (int i = 0; i < 20; i++) begin
            if (door_open) cnt++;
            if (cmd_if.cmd_valid) saw_valid = 1'b1;
            tick();
        end
        vectors++;
        if (cnt !== 8) begin
            miscompares++;
            $display("[TB] FAIL here_restart: door_open cycles after repeat=%0d required 8", cnt);
        end
        vectors++;
        if (saw_valid !== 1'b0 || pending !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL here_nocmd: saw_valid=%b pending=%b required 0/0000", saw_valid, pending);
        end
    endtask

    task automatic test_done_coincident();
        call_pe = 4'b1000;
        tick();
        call_pe = '0;
        wait_valid("coin_issue");
        vectors++;
        if ({cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== {2'd3, 1'b0, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL coin_cmd: target/dir/dist=%0d/%b/%0d required 3/0/2",
                     cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist);
        end
        tick();
        call_pe = 4'b0010;
        tick();
        call_pe = '0;
        vectors++;
        if (pending !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL coin_depart_latch: pending=%b required 1010", pending);
        end
        cmd_if.motor_done = 1'b1;
        call_pe = 4'b1000;
        tick();
        cmd_if.motor_done = 1'b0;
        call_pe = '0;
        vectors++;
        if (pending !== 4'b0010 || current_floor !== 2'd3 || door_open !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coin_clear: pending=%b floor=%0d door=%b required 0010/3/1",
                     pending, current_floor, door_open);
        end
        wait_valid("coin_return");
        vectors++;
        if ({cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist} !== {2'd1, 1'b1, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL coin_return: target/dir/dist=%0d/%b/%0d required 1/1/2",
                     cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist);
        end
        tick();
        pulse_done();
        wait_idle("coin");
        pulse_done();
        tick();
        vectors++;
        if ({door_open, moving, cmd_if.cmd_valid, current_floor, pending} !== {3'b000, 2'd1, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL stray_done: door/moving/valid=%b%b%b floor=%0d pending=%b required 000/1/0000",
                     door_open, moving, cmd_if.cmd_valid, current_floor, pending);
        end
    endtask

    task automatic test_reset_mid_move();
        call_pe = 4'b0001;
        tick();
        call_pe = '0;
        wait_valid("rst_issue");
        tick();
        vectors++;
        if (moving !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_moving: moving=%b required 1", moving);
        end
        #1;
        reset_p = 1'b1;
        #1;
        vectors++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_target, cmd_if.cmd_dir, cmd_if.cmd_dist,
             current_floor, pending, moving, door_open} !== 14'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: valid/target/floor/moving/door=%b/%0d/%0d/%b/%b required all 0",
                     cmd_if.cmd_valid, cmd_if.cmd_target, current_floor, moving, door_open);
        end
        tick();
        reset_p = 1'b0;
        tick();
    endtask

`ifdef ELEV_DOOR_HOLD_EN
    task automatic test_door_hold();
        int cnt = 0;
        call_pe = 4'b0001;
        tick();
        call_pe = '0;
        door_hold = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) door_hold = 1'b0;
            if (door_open) cnt++;
            tick();
        end
        vectors++;
        if (cnt !== 28) begin
            miscompares++;
            $display("[TB] FAIL door_hold: door_open cycles=%0d required 28", cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_move();
        test_scan_order();
        test_backpressure();
        test_current_floor_call();
        test_done_coincident();
        test_reset_mid_move();
`ifdef ELEV_DOOR_HOLD_EN
        test_door_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
